// File: rtl/hog_cell_hist.sv
// 9-bin unsigned-orientation histogram per CELL_PIX samples; sample->bin 1 clk, ->acc/output 2 clk; no upstream stall.
// Output holds until o_ready; optional HOG_CELL_HIST_OVF_EN drops a cell that finds the output full and sets sticky o_ovf.
module hog_cell_hist #(
  parameter int MAG_W    = 13,
  parameter int TAN_I    = 4,
  parameter int TAN_F    = 16,
  parameter int CELL_PIX = 64,
  parameter int BIN_W    = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [MAG_W-1:0]         magnitude,
  input  logic [TAN_I+TAN_F-1:0]   tan,
  output logic [9*BIN_W-1:0]       o_hist,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     o_ovf
);

  localparam int TW    = TAN_I + TAN_F;
  localparam int CNT_W = $clog2(CELL_PIX);

  // Thresholds are tan(20/40/60/80 deg) in Q.16, rescaled to the tan fraction width.
  localparam logic signed [TW-1:0] T1 = TW'((64'd23853  << TAN_F) >> 16);
  localparam logic signed [TW-1:0] T2 = TW'((64'd54991  << TAN_F) >> 16);
  localparam logic signed [TW-1:0] T3 = TW'((64'd113512 << TAN_F) >> 16);
  localparam logic signed [TW-1:0] T4 = TW'((64'd371674 << TAN_F) >> 16);

  logic signed [TW-1:0] tan_s;
  logic [3:0]           bin_d;
  logic                 s1_vld;
  logic [3:0]           s1_bin;
  logic [MAG_W-1:0]     s1_mag;
  logic [CNT_W-1:0]     cnt;
  logic [BIN_W-1:0]     acc [9];
  logic [BIN_W-1:0]     mag_x;
  logic [9*BIN_W-1:0]   hist_d;
  logic                 last;
  logic                 take;

  assign tan_s = $signed(tan);

  always_comb begin
    bin_d = 4'd4;
    if (!tan_s[TW-1]) begin
      if      (tan_s < T1) bin_d = 4'd0;
      else if (tan_s < T2) bin_d = 4'd1;
      else if (tan_s < T3) bin_d = 4'd2;
      else if (tan_s < T4) bin_d = 4'd3;
    end else begin
      if      (tan_s >= -T1) bin_d = 4'd8;
      else if (tan_s >= -T2) bin_d = 4'd7;
      else if (tan_s >= -T3) bin_d = 4'd6;
      else if (tan_s >= -T4) bin_d = 4'd5;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_bin <= 4'd0;
      s1_mag <= '0;
    end else begin
      s1_vld <= i_valid;
      if (i_valid) begin
        s1_bin <= bin_d;
        s1_mag <= magnitude;
      end
    end
  end

  assign mag_x = BIN_W'(s1_mag);
  assign last  = s1_vld && (cnt == CNT_W'(CELL_PIX - 1));
  assign take  = o_valid && o_ready;

  // Sums including the current sample; feeds both the running accumulators and the output on the last sample.
  always_comb begin
    hist_d = '0;
    for (int k = 0; k < 9; k++) begin
      hist_d[k*BIN_W +: BIN_W] = acc[k] + ((s1_bin == 4'(k)) ? mag_x : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      for (int k = 0; k < 9; k++) acc[k] <= '0;
    end else if (s1_vld) begin
      cnt <= cnt + 1'b1;
      for (int k = 0; k < 9; k++) acc[k] <= last ? '0 : hist_d[k*BIN_W +: BIN_W];
    end
  end

`ifdef HOG_CELL_HIST_OVF_EN
  logic room;
  assign room = !o_valid || o_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_hist  <= '0;
      o_ovf   <= 1'b0;
    end else begin
      if (take) o_valid <= 1'b0;
      if (last && room) begin
        o_hist  <= hist_d;
        o_valid <= 1'b1;
      end
      if (last && !room) o_ovf <= 1'b1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid <= 1'b0;
      o_hist  <= '0;
    end else begin
      if (take) o_valid <= 1'b0;
      if (last) begin
        o_hist  <= hist_d;
        o_valid <= 1'b1;
      end
    end
  end

  assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_hog_cell_hist.sv
// Directed bench for hog_cell_hist: spec-level model checked every cycle plus hand-computed literal histograms.
module tb_hog_cell_hist;
  localparam int MAG_W = 13;
  localparam int TW    = 20;
  localparam int BIN_W = 19;
  localparam int NB    = 9;
  localparam int CP    = 64;
  localparam int T1 = 23853, T2 = 54991, T3 = 113512, T4 = 371674;
  localparam int HW = NB * BIN_W;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           i_valid = 1'b0;
  logic [MAG_W-1:0] magnitude = '0;
  logic [TW-1:0]  tan = '0;
  logic [HW-1:0]  o_hist;
  logic           o_valid;
  logic           o_ready = 1'b0;
  logic           o_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hog_cell_hist dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .magnitude(magnitude), .tan(tan),
    .o_hist(o_hist), .o_valid(o_valid), .o_ready(o_ready), .o_ovf(o_ovf)
  );

  task automatic chk(input string nm, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [HW-1:0] hv(input int b, input int v);
    logic [HW-1:0] h;
    h = '0;
    h[b*BIN_W +: BIN_W] = v[BIN_W-1:0];
    return h;
  endfunction

  // Orientation bin from the angle-sector rules: positive tan counts thresholds reached,
  // negative tan mirrors around 180 degrees.
  function automatic int bin_of(input int t);
    int thr[4];
    int c;
    thr = '{T1, T2, T3, T4};
    c = 0;
    if (t >= 0) begin
      foreach (thr[k]) if (thr[k] <= t) c++;
      return c;
    end
    foreach (thr[k]) if (thr[k] < -t) c++;
    return 8 - c;
  endfunction

  typedef struct {
    int            due;
    logic [HW-1:0] h;
  } ev_t;

  ev_t           pend[$];
  ev_t           md_ev;
  int            m_acc[NB];
  int            m_cnt;
  int            edge_n = 0;
  int            md_b;
  int            md_t;
  logic          md_room;
  logic          m_vld;
  logic          m_ovf;
  logic [HW-1:0] m_hist;
  logic [HW-1:0] md_h;
  logic [HW-1:0] got[$];

  // Reference model: sample captured at edge E completes its cell at edge E+1.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_acc[k]) m_acc[k] = 0;
      m_cnt  = 0;
      m_vld  = 1'b0;
      m_ovf  = 1'b0;
      m_hist = '0;
      pend.delete();
    end else begin
      edge_n++;
      md_room = !m_vld || o_ready;
      if (m_vld && o_ready) m_vld = 1'b0;
      if (pend.size() > 0 && pend[0].due == edge_n) begin
        md_ev = pend.pop_front();
`ifdef HOG_CELL_HIST_OVF_EN
        if (md_room) begin
          m_hist = md_ev.h;
          m_vld  = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
`else
        m_hist = md_ev.h;
        m_vld  = 1'b1;
`endif
      end
      if (i_valid) begin
        md_t = $signed(tan);
        md_b = bin_of(md_t);
        m_acc[md_b] = (m_acc[md_b] + int'(magnitude)) % (1 << BIN_W);
        m_cnt++;
        if (m_cnt == CP) begin
          md_h = '0;
          for (int k = 0; k < NB; k++) md_h = md_h | hv(k, m_acc[k]);
          pend.push_back('{due: edge_n + 1, h: md_h});
          foreach (m_acc[k]) m_acc[k] = 0;
          m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("cyc_o_valid", HW'(o_valid), HW'(m_vld));
      chk("cyc_o_ovf", HW'(o_ovf), HW'(m_ovf));
      if (m_vld) chk("cyc_o_hist", o_hist, m_hist);
      if (o_valid && o_ready) got.push_back(o_hist);
    end
  end

  task automatic send(input int t, input int m);
    @(posedge clk); #1;
    i_valid   = 1'b1;
    tan       = t[TW-1:0];
    magnitude = m[MAG_W-1:0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
    end
  endtask

  task automatic check_got(input string nm, input int idx, input logic [HW-1:0] exp);
    if (got.size() > idx) chk(nm, got[idx], exp);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no histogram accepted (have %0d, need index %0d)", nm, got.size(), idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int drops;
    logic [HW-1:0] e;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_o_valid", HW'(o_valid), '0);
    chk("rst_o_hist", o_hist, '0);
    chk("rst_o_ovf", HW'(o_ovf), '0);
    @(posedge clk); #2;
    rst     = 1'b1;
    o_ready = 1'b1;

    // One bin0 cell; pulse exactly two edges after the last sample
    base = got.size();
    for (int i = 0; i < CP; i++) send(0, 16);
    idle(1);
    chk("lat_n1_o_valid", HW'(o_valid), '0);
    idle(1);
    chk("lat_n2_o_valid", HW'(o_valid), HW'(1));
    chk("lat_n2_o_hist", o_hist, hv(0, 1024));
    idle(1);
    chk("lat_n3_o_valid", HW'(o_valid), '0);
    idle(2);
    check_got("bin0_cell", base, hv(0, 1024));

    // Every bin boundary lands in the upper bin
    base = got.size();
    begin
      int tv[9];
      tv = '{0, T1, T2, T3, T4, -T4, -T3, -T2, -T1};
      foreach (tv[b]) for (int j = 0; j < 7; j++) send(tv[b], 5);
    end
    send(-1, 5);
    idle(4);
    e = hv(8, 40);
    for (int b = 0; b < 8; b++) e = e | hv(b, 35);
    check_got("boundaries", base, e);

    // Saturated tan, maximum magnitude
    base = got.size();
    for (int i = 0; i < CP; i++) send((i % 2) ? -524288 : 524287, 8191);
    idle(4);
    check_got("sat_bin4", base, hv(4, 524224));

    // Two cells while output blocked
    o_ready = 1'b0;
    base = got.size();
    for (int i = 0; i < CP; i++) send(0, 1);
    for (int i = 0; i < CP; i++) send(T1, 2);
    idle(4);
`ifdef HOG_CELL_HIST_OVF_EN
    chk("blk_o_hist", o_hist, hv(0, 64));
    chk("blk_o_ovf", HW'(o_ovf), HW'(1));
`else
    chk("blk_o_hist", o_hist, hv(1, 128));
    chk("blk_o_ovf", HW'(o_ovf), '0);
`endif
    o_ready = 1'b1;
    idle(3);
`ifdef HOG_CELL_HIST_OVF_EN
    check_got("blk_kept", base, hv(0, 64));
`else
    check_got("blk_kept", base, hv(1, 128));
`endif
    chk("blk_count", HW'(got.size() - base), HW'(1));

    // Accept on the exact completion edge: back-to-back, nothing lost
    o_ready = 1'b0;
    base  = got.size();
    drops = 0;
    for (int i = 0; i < 3 * CP; i++) begin
      @(posedge clk); #1;
      if (i >= CP + 1 && !o_valid) drops++;
      i_valid   = 1'b1;
      tan       = '0;
      magnitude = MAG_W'(i / CP + 1);
      o_ready   = (i == 2 * CP);
    end
    @(posedge clk); #1;
    if (!o_valid) drops++;
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(posedge clk); #1;
    if (!o_valid) drops++;
    o_ready = 1'b0;
    @(posedge clk); #1;
    if (!o_valid) drops++;
    o_ready = 1'b1;
    idle(3);
    chk("b2b_no_drop", HW'(drops), '0);
    check_got("b2b_cell0", base, hv(0, 64));
    check_got("b2b_cell1", base + 1, hv(0, 128));
    check_got("b2b_cell2", base + 2, hv(0, 192));

    // Asynchronous reset mid-cell with a histogram pending
    o_ready = 1'b0;
    for (int i = 0; i < CP; i++) send(0, 7);
    for (int i = 0; i < 30; i++) send(T2, 3);
    #2;
    rst     = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("arst_o_valid", HW'(o_valid), '0);
    chk("arst_o_hist", o_hist, '0);
    chk("arst_o_ovf", HW'(o_ovf), '0);
    @(posedge clk); #2;
    rst     = 1'b1;
    o_ready = 1'b1;
    base = got.size();
    for (int i = 0; i < CP; i++) send(-T4, 9);
    idle(4);
    check_got("post_rst", base, hv(5, 576));
    chk("post_rst_count", HW'(got.size() - base), HW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
